uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the CPU peripheral bus. It captures each byte the receiver announces with its one-cycle `rx_status` pulse and stores it in a circular FIFO. The CPU drains the FIFO with a read strobe. The block reports fill level, raises a threshold interrupt and flags overrun, so bursts at the serial line do not lose data while the pipeline is stalled.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default).
- `IRQ_THRESHOLD`, 1: `irq` asserts when `count >= IRQ_THRESHOLD`. Legal range is 1..2^DEPTH_LOG2.
- `clk_50m`  in  1: system clock; every register updates on the rising edge.
- `reset_b`  in  1: asynchronous, active-low reset.
- `rx_status`  in  1: byte-ready strobe from the UART receiver; only its rising edge is used.
- `rx_data`  in  8: received byte, stable while `rx_status` is high.
- `rd_en`  in  1: CPU pop request, sampled on the clock edge.
- `overrun_clr`  in  1: clears the sticky `overrun` flag.
- `rd_data`  out  8: byte delivered to the CPU.
- `rd_valid`  out  1: `rd_data` holds a valid popped or head byte.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == 2^DEPTH_LOG2`.
- `count`  out  DEPTH_LOG2+1: number of stored bytes.
- `overrun`  out  1: sticky flag; a byte was dropped because the FIFO was full.
- `irq`  out  1: level interrupt, high while `count >= IRQ_THRESHOLD`.

## Operation
- **Reset:** all pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `overrun` = 0, `rd_data` = 8'h00, `rd_valid` = 0, `irq` = 0. The edge-detect register also resets to 0. Reset mid-operation discards stored bytes immediately.
- **Write detect:** the block registers `rx_status_d`. A write occurs when `wr_stb = rx_status & ~rx_status_d`, so exactly one write happens per receiver pulse, even if `rx_status` stays high for several cycles.
- **Storage:** memory of 2^DEPTH_LOG2 x 8 bits.
  - Write pointer and read pointer are each DEPTH_LOG2 bits and wrap modulo the depth.
  - `count` is a separate up/down counter.
- **Write:** when `wr_stb` is high and the FIFO is not full, the block stores `mem[wr_ptr] <= rx_data`, increments `wr_ptr`, and increments `count`.
- **Write when full:**
  - If `rd_en` is also high that cycle, the pop frees a slot. The byte is stored and `count` is unchanged.
  - Otherwise the byte is dropped, `overrun` is set, and the pointers and `count` are unchanged.
- **Read:** when `rd_en` is high and `empty` is 0, the block pops the head, increments `rd_ptr`, and decrements `count`. When `rd_en` is high and `empty` is 1, nothing happens: no error, pointers unchanged.
- **Simultaneous write and read:**
  - FIFO non-empty: both occur and `count` is unchanged.
  - FIFO empty: the read is ignored and the write is accepted.
- **Overrun flag:** `overrun_clr` clears `overrun` on the next edge. If a set event and `overrun_clr` occur in the same cycle, set wins.
- **Flags:** `empty`, `full` and `irq` are derived from `count`, combinationally or registered in step with it, and are always consistent with `count`.

## Timing
- **Write latency:** `rx_status` rising at edge N produces `wr_stb` high during cycle N. Data is stored at edge N+1, and `count` and `empty` update at that same edge.
- **Non-FWFT read:**
  - `rd_en` sampled high at edge M (FIFO non-empty): `rd_data` = head byte and `rd_valid` = 1 from edge M.
  - `rd_valid` is a 1-cycle pulse per accepted pop.
  - `rd_data` holds its value until the next accepted pop.
- **Irq latency:** `irq` follows `count` with the same-edge update and has no extra latency.
- **Throughput:** one write and one read per cycle sustained.

## Configuration
- **`UART_RX_FIFO_FWFT_EN` defined (first-word-fall-through):**
  - `rd_data` always presents `mem[rd_ptr]`; `rd_valid = ~empty`.
  - `rd_en` acknowledges and removes the shown byte. The next head appears the cycle after the pop edge.
  - The first written byte is visible the cycle after its write edge.
- **Not defined:** registered read as described under Operation and Timing. `rd_data` only changes on an accepted pop, and `rd_valid` is a 1-cycle pulse.

## Test plan
- **Reset and basic write/read:** reset, then three `rx_status` pulses carrying 8'hA5, 8'h3C, 8'hFF.
  - Required: `count` = 3.
  - Then three `rd_en` pulses: `rd_data` sequence A5, 3C, FF, each with one `rd_valid` cycle; `empty` = 1 afterwards.
- **Long strobe:** `rx_status` held high for 4 cycles with data 8'h11.
  - Required: exactly one entry, `count` = 1.
- **Fill and overrun:** 16 writes 0x00..0x0F, then a 17th write 0x55 with `rd_en` = 0.
  - Required: `full` = 1, `overrun` = 1, `count` = 16.
  - Reading out 16 bytes returns 0x00..0x0F; 0x55 is absent.
- **Full plus simultaneous read/write:** with the FIFO full, write 0x77 in the same cycle as `rd_en`.
  - Required: pops 0x00, `count` stays 16, `overrun` stays 0.
  - Then drain: 0x01..0x0F, then 0x77, confirming pointer wrap-around.
- **Empty reads and overrun clear/set collision:**
  - `rd_en` on an empty FIFO → `rd_valid` = 0, `count` = 0.
  - `overrun_clr` coinciding with a new overrun event → `overrun` stays 1; `overrun_clr` alone on a later cycle → `overrun` = 0.
- **Irq and reset mid-operation:** with IRQ_THRESHOLD = 4, write 4 bytes.
  - Required: `irq` rises at the 4th write edge; one pop drops `irq`.
  - Assert `reset_b` = 0 asynchronously with 3 bytes stored: `count`, `irq` and `rd_valid` go to 0 immediately, and `empty` goes to 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the CPU bus.
// Bytes announced by a rising edge on rx_status are queued in a circular
// FIFO of 2^DEPTH_LOG2 entries. The CPU drains it with rd_en. The block
// reports the fill level, raises a level interrupt at a threshold and keeps
// a sticky overrun flag for bytes dropped while full.
//
// Optional feature macro: UART_RX_FIFO_FWFT_EN
//   defined   : first-word-fall-through; rd_data shows the head entry and
//               rd_valid = ~empty.
//   undefined : registered read; rd_data updates only on an accepted pop
//               and rd_valid is a one-cycle pulse per pop.
//
// Ports
//   clk_50m      in   system clock, rising edge
//   reset_b      in   asynchronous active-low reset
//   rx_status    in   byte-ready strobe; only its rising edge writes
//   rx_data      in   received byte
//   rd_en        in   CPU pop request
//   overrun_clr  in   clears the sticky overrun flag
//   rd_data      out  byte delivered to the CPU
//   rd_valid     out  rd_data holds a popped (or head) byte
//   empty        out  count == 0
//   full         out  count == depth
//   count        out  number of stored bytes
//   overrun      out  sticky: a byte was dropped while full
//   irq          out  high while count >= IRQ_THRESHOLD
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned IRQ_THRESHOLD = 1
) (
  input  logic                  clk_50m,
  input  logic                  reset_b,
  input  logic                  rx_status,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  input  logic                  overrun_clr,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  irq
);

  localparam int unsigned         DEPTH_C    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT_C = DEPTH_C[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] IRQ_CNT_C  = IRQ_THRESHOLD[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] ZERO_CNT_C = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE_C  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = CNT_ONE_C[DEPTH_LOG2-1:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_C = ZERO_CNT_C[DEPTH_LOG2-1:0];

  logic                  rx_status_d_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  irq_r;
  logic                  overrun_r;
  logic [7:0]            mem_r [DEPTH_C];

  logic                  wr_stb_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ovr_set_s;
  logic [DEPTH_LOG2:0]   count_nxt_s;

  // Write/read acceptance and next fill level.
  always_comb begin
    wr_stb_s = rx_status & ~rx_status_d_r;
    rd_acc_s = rd_en & ~empty_r;
    // When full, a write only fits if the same-cycle pop frees a slot.
    if (full_r) begin
      wr_acc_s  = wr_stb_s & rd_acc_s;
      ovr_set_s = wr_stb_s & ~rd_acc_s;
    end else begin
      wr_acc_s  = wr_stb_s;
      ovr_set_s = 1'b0;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, counter, edge detect and flags; flags are registered from the
  // next count so they always change on the same edge as count.
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      rx_status_d_r <= 1'b0;
      wr_ptr_r      <= PTR_ZERO_C;
      rd_ptr_r      <= PTR_ZERO_C;
      count_r       <= ZERO_CNT_C;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      irq_r         <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      rx_status_d_r <= rx_status;
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == ZERO_CNT_C);
      full_r  <= (count_nxt_s == FULL_CNT_C);
      irq_r   <= (count_nxt_s >= IRQ_CNT_C);
      // A new drop in the same cycle as a clear keeps the flag set.
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Storage array; cleared on reset so no stale byte is ever presented.
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH_C; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Head entry is always on the bus; a pop exposes the next one a cycle later.
  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = ~empty_r;
`else
  logic [7:0] rd_data_r;
  logic       rd_valid_r;

  // Registered read: data captured and valid pulsed on each accepted pop.
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
`endif

  assign empty   = empty_r;
  assign full    = full_r;
  assign count   = count_r;
  assign overrun = overrun_r;
  assign irq     = irq_r;

endmodule
